// File: rtl/retire_ctrl.sv
// retire_ctrl: consumer end of the ROB commit port. Retires head entries in order,
// updates the retirement map, releases stores and sequences mispredict/exception flushes.
package retire_ctrl_pkg;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned PHYS_W    = $clog2(PHYS_REGS);
  localparam int unsigned ARCH_W    = 5;
  localparam int unsigned PC_W      = 32;

  typedef struct packed {
    logic              uses_rd;
    logic [ARCH_W-1:0] rd_arch;
    logic [PHYS_W-1:0] pd_new;
    logic              is_store;
    logic              is_branch;
    logic              mispredict;
    logic              exception;
    logic [PC_W-1:0]   target_pc;
  } rob_entry_t;
endpackage

module retire_ctrl
  import retire_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE  = 16,
  parameter int unsigned ROB_W     = $clog2(ROB_SIZE),
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned MIN_DRAIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  rob_entry_t        commit_entry,
  input  logic [ROB_W-1:0]  commit_rob_idx,
  input  logic [1:0]        global_epoch,
  input  logic              recover_valid,
  output logic              store_commit_valid,
  input  logic              store_commit_ready,
  output logic              arf_we,
  output logic [4:0]        arf_rd,
  output logic [PHYS_W-1:0] arf_pd,
  output logic              flush_valid,
  output logic [ROB_W-1:0]  flush_rob_idx,
  output logic [1:0]        flush_epoch,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [31:0]       retired_count
);

  localparam int unsigned CNT_W = $clog2(MIN_DRAIN + 1);
  localparam logic [CNT_W-1:0] DRAIN_MIN = CNT_W'(MIN_DRAIN);
  localparam logic [CNT_W-1:0] DRAIN_ONE = CNT_W'(1);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic             run_ok;
  logic             fire;
  logic             flush_take;
  logic             drain_done;
  logic             entry_unused;

  // The branch flag only matters upstream; the flush decision rests on mispredict.
  assign entry_unused = commit_entry.is_branch;

  // Commit handshake, store release and retirement-map write decode.
  always_comb begin
    run_ok             = (state == RUN) && !rst;
    store_commit_valid = run_ok && commit_valid && commit_entry.is_store;
    commit_ready       = run_ok && commit_valid &&
                         (!commit_entry.is_store || store_commit_ready);
    fire               = commit_ready;
    flush_take         = fire && (commit_entry.mispredict || commit_entry.exception);
    arf_we             = fire && commit_entry.uses_rd && (commit_entry.rd_arch != '0);
    arf_rd             = fire ? commit_entry.rd_arch : '0;
    arf_pd             = fire ? commit_entry.pd_new : '0;
    drain_done         = (drain_cnt >= DRAIN_MIN) && !recover_valid;
    flush_epoch        = flush_valid ? 2'(global_epoch + 2'd1) : 2'd0;
  end

  assign redirect_valid = flush_valid;

  // Retire/flush/drain sequencer with registered flush outputs and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      drain_cnt     <= '0;
      flush_valid   <= 1'b0;
      flush_rob_idx <= '0;
      redirect_pc   <= '0;
      retired_count <= '0;
    end else begin
      retired_count <= retired_count + 32'(fire);
      flush_valid   <= 1'b0;
      unique case (state)
        RUN: begin
          if (flush_take) begin
            state         <= FLUSH;
            flush_valid   <= 1'b1;
            flush_rob_idx <= commit_rob_idx;
            // Exception wins over mispredict for the redirect target.
            redirect_pc   <= commit_entry.exception ? TRAP_VEC : commit_entry.target_pc;
          end
        end
        FLUSH: begin
          state     <= DRAIN;
          drain_cnt <= DRAIN_ONE;
        end
        DRAIN: begin
          if (drain_done) begin
            state <= RUN;
          end else if (drain_cnt < DRAIN_MIN) begin
            drain_cnt <= drain_cnt + DRAIN_ONE;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_ctrl.sv
// Self-checking bench for retire_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_retire_ctrl;
  import retire_ctrl_pkg::*;

  localparam int unsigned ROB_W     = 4;
  localparam logic [31:0] TRAP      = 32'h0000_0100;
  localparam int          MIN_DRAIN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit_valid;
  logic              commit_ready;
  rob_entry_t        commit_entry;
  logic [ROB_W-1:0]  commit_rob_idx;
  logic [1:0]        global_epoch;
  logic              recover_valid;
  logic              store_commit_valid;
  logic              store_commit_ready;
  logic              arf_we;
  logic [4:0]        arf_rd;
  logic [PHYS_W-1:0] arf_pd;
  logic              flush_valid;
  logic [ROB_W-1:0]  flush_rob_idx;
  logic [1:0]        flush_epoch;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [31:0]       retired_count;

  always #5 clk = ~clk;

  retire_ctrl #(.ROB_SIZE(16), .TRAP_VEC(TRAP), .MIN_DRAIN(MIN_DRAIN)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_entry(commit_entry), .commit_rob_idx(commit_rob_idx),
    .global_epoch(global_epoch), .recover_valid(recover_valid),
    .store_commit_valid(store_commit_valid), .store_commit_ready(store_commit_ready),
    .arf_we(arf_we), .arf_rd(arf_rd), .arf_pd(arf_pd),
    .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx), .flush_epoch(flush_epoch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .retired_count(retired_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: age of the pending flush (-1 none, 0 pulse cycle, n = n-th drain cycle).
  int               m_age;
  logic [31:0]      m_cnt;
  logic [31:0]      m_pc;
  logic [ROB_W-1:0] m_idx;
  logic             m_fire;

  typedef struct {
    logic cv; logic st; logic scr; logic urd;
    logic [4:0] rd; logic [PHYS_W-1:0] pd;
    logic e_ready; logic e_scv; logic e_we;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_op(input logic st, input logic urd, input logic [4:0] rd,
                        input logic [PHYS_W-1:0] pd, input logic mp, input logic ex,
                        input logic [31:0] tpc);
    commit_entry            = '0;
    commit_entry.is_store   = st;
    commit_entry.uses_rd    = urd;
    commit_entry.rd_arch    = rd;
    commit_entry.pd_new     = pd;
    commit_entry.is_branch  = mp;
    commit_entry.mispredict = mp;
    commit_entry.exception  = ex;
    commit_entry.target_pc  = tpc;
  endtask

  task automatic model_check();
    logic blocked, e_ready, e_scv, e_flush;
    blocked = (m_age >= 0) || rst;
    e_ready = !blocked && commit_valid && (!commit_entry.is_store || store_commit_ready);
    e_scv   = !blocked && commit_valid && commit_entry.is_store;
    e_flush = (m_age == 0);
    m_fire  = e_ready;
    chk("m_commit_ready", 32'(commit_ready), 32'(e_ready));
    chk("m_store_commit_valid", 32'(store_commit_valid), 32'(e_scv));
    chk("m_arf_we", 32'(arf_we),
        32'(e_ready && commit_entry.uses_rd && (commit_entry.rd_arch != 5'd0)));
    if (e_ready) begin
      chk("m_arf_rd", 32'(arf_rd), 32'(commit_entry.rd_arch));
      chk("m_arf_pd", 32'(arf_pd), 32'(commit_entry.pd_new));
    end
    chk("m_flush_valid", 32'(flush_valid), 32'(e_flush));
    chk("m_redirect_valid", 32'(redirect_valid), 32'(e_flush));
    if (e_flush) chk("m_flush_epoch", 32'(flush_epoch), (32'(global_epoch) + 32'd1) % 32'd4);
    chk("m_flush_rob_idx", 32'(flush_rob_idx), 32'(m_idx));
    chk("m_redirect_pc", redirect_pc, m_pc);
    chk("m_retired_count", retired_count, m_cnt);
  endtask

  task automatic model_update();
    if (rst) begin
      m_age = -1; m_cnt = '0; m_idx = '0; m_pc = '0;
    end else if (m_fire) begin
      m_cnt = m_cnt + 32'd1;
      if (commit_entry.mispredict || commit_entry.exception) begin
        m_age = 0;
        m_idx = commit_rob_idx;
        m_pc  = commit_entry.exception ? TRAP : commit_entry.target_pc;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (m_age > 0) begin
      if (m_age >= MIN_DRAIN && !recover_valid) m_age = -1;
      else m_age = m_age + 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  6'd10, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  6'd10, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd3,  6'd11, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  6'd12, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  6'd0,  1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  6'd0,  1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 6'd63, 1'b1, 1'b1, 1'b1};

    m_age = -1; m_cnt = '0; m_pc = '0; m_idx = '0; m_fire = 1'b0;
    rst = 1'b1; commit_valid = 1'b0; commit_entry = '0; commit_rob_idx = '0;
    global_epoch = 2'd0; recover_valid = 1'b0; store_commit_ready = 1'b0;
    step(); step();
    chk("reset_count", retired_count, 32'd0);
    chk("reset_flush_valid", 32'(flush_valid), 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;

    // Three ALU ops back to back.
    commit_valid = 1'b1;
    set_op(1'b0, 1'b1, 5'd5, 6'd40, 1'b0, 1'b0, 32'h0); #1;
    chk("alu1_ready", 32'(commit_ready), 32'd1);
    chk("alu1_we", 32'(arf_we), 32'd1); chk("alu1_pd", 32'(arf_pd), 32'd40);
    step();
    set_op(1'b0, 1'b1, 5'd6, 6'd41, 1'b0, 1'b0, 32'h0); #1;
    chk("alu2_we", 32'(arf_we), 32'd1); chk("alu2_pd", 32'(arf_pd), 32'd41);
    step();
    set_op(1'b0, 1'b1, 5'd0, 6'd42, 1'b0, 1'b0, 32'h0); #1;
    chk("alu3_we", 32'(arf_we), 32'd0);
    step();
    commit_valid = 1'b0; #1;
    chk("alu_count", retired_count, 32'd3);

    // Store stalled by the LSU for four cycles.
    set_op(1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 32'h0);
    commit_valid = 1'b1; store_commit_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("st_wait_ready", 32'(commit_ready), 32'd0);
      chk("st_wait_scv", 32'(store_commit_valid), 32'd1);
      step();
    end
    store_commit_ready = 1'b1; #1;
    chk("st_fire_ready", 32'(commit_ready), 32'd1);
    step();
    commit_valid = 1'b0; store_commit_ready = 1'b0; #1;
    chk("st_count", retired_count, 32'd4);

    // Mispredict with epoch wrap.
    global_epoch = 2'd3; commit_rob_idx = 4'd7;
    set_op(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 32'h2000);
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0; #1;
    chk("mp_flush_valid", 32'(flush_valid), 32'd1);
    chk("mp_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("mp_flush_idx", 32'(flush_rob_idx), 32'd7);
    chk("mp_flush_epoch", 32'(flush_epoch), 32'd0);
    chk("mp_redirect_pc", redirect_pc, 32'h2000);
    step(); step(); step();
    chk("mp_count", retired_count, 32'd5);

    // Exception + mispredict, recovery walk held for five cycles.
    global_epoch = 2'd1; commit_rob_idx = 4'd9;
    set_op(1'b0, 1'b1, 5'd2, 6'd3, 1'b1, 1'b1, 32'h3000);
    commit_valid = 1'b1;
    step();
    set_op(1'b0, 1'b1, 5'd4, 6'd20, 1'b0, 1'b0, 32'h0); #1;
    chk("ex_flush_valid", 32'(flush_valid), 32'd1);
    chk("ex_redirect_pc", redirect_pc, TRAP);
    chk("ex_flush_epoch", 32'(flush_epoch), 32'd2);
    chk("ex_ready_flush", 32'(commit_ready), 32'd0);
    step();
    recover_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1; chk("ex_ready_recover", 32'(commit_ready), 32'd0);
      step();
    end
    recover_valid = 1'b0; #1;
    chk("ex_ready_last_drain", 32'(commit_ready), 32'd0);
    step(); #1;
    chk("ex_ready_resume", 32'(commit_ready), 32'd1);
    step();
    commit_valid = 1'b0;

    // Vector table in RUN.
    for (int i = 0; i < 8; i++) begin
      commit_valid = tbl[i].cv; store_commit_ready = tbl[i].scr;
      set_op(tbl[i].st, tbl[i].urd, tbl[i].rd, tbl[i].pd, 1'b0, 1'b0, 32'h0); #1;
      chk("vec_ready", 32'(commit_ready), 32'(tbl[i].e_ready));
      chk("vec_scv", 32'(store_commit_valid), 32'(tbl[i].e_scv));
      chk("vec_we", 32'(arf_we), 32'(tbl[i].e_we));
      step();
    end
    store_commit_ready = 1'b0;

    // Reset during DRAIN aborts the flush.
    set_op(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 32'h0);
    commit_rob_idx = 4'd3; commit_valid = 1'b1;
    step();
    set_op(1'b0, 1'b1, 5'd8, 6'd9, 1'b0, 1'b0, 32'h0);
    step();
    recover_valid = 1'b1; rst = 1'b1;
    step(); #1;
    chk("rstd_ready", 32'(commit_ready), 32'd0);
    chk("rstd_scv", 32'(store_commit_valid), 32'd0);
    chk("rstd_we", 32'(arf_we), 32'd0);
    chk("rstd_rd", 32'(arf_rd), 32'd0);
    chk("rstd_pd", 32'(arf_pd), 32'd0);
    chk("rstd_flush_valid", 32'(flush_valid), 32'd0);
    chk("rstd_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rstd_epoch", 32'(flush_epoch), 32'd0);
    chk("rstd_idx", 32'(flush_rob_idx), 32'd0);
    chk("rstd_pc", redirect_pc, 32'd0);
    chk("rstd_count", retired_count, 32'd0);
    step();
    rst = 1'b0; recover_valid = 1'b0; #1;
    chk("rstd_resume_ready", 32'(commit_ready), 32'd1);
    step();

    // Reset during the FLUSH pulse: no pulse afterwards.
    set_op(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 32'h4000);
    step();
    set_op(1'b0, 1'b1, 5'd8, 6'd9, 1'b0, 1'b0, 32'h0); #1;
    chk("rstf_pulse", 32'(flush_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("rstf_no_pulse", 32'(flush_valid), 32'd0);
    chk("rstf_ready", 32'(commit_ready), 32'd1);
    step();

    // Counter wrap from 32'hFFFF_FFFE.
    commit_valid = 1'b0;
    force dut.retired_count = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    step();
    release dut.retired_count;
    #1; chk("wrap_preload", retired_count, 32'hFFFF_FFFE);
    commit_valid = 1'b1;
    set_op(1'b0, 1'b1, 5'd1, 6'd1, 1'b0, 1'b0, 32'h0);
    step(); step();
    commit_valid = 1'b0; #1;
    chk("wrap_count", retired_count, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      commit_valid       = ($urandom_range(0, 99) < 70);
      store_commit_ready = ($urandom_range(0, 99) < 60);
      set_op($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 80, 5'($urandom),
             6'($urandom), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5, $urandom);
      commit_rob_idx = 4'($urandom);
      global_epoch   = 2'($urandom);
      recover_valid  = ($urandom_range(0, 99) < ((m_age >= 1) ? 50 : 30));
      rst            = ($urandom_range(0, 99) < 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
